// File: rtl/wb_select_stage.sv
// wb_select_stage: the registered write-back selector that sits between the MEM stage
// and the register file.
//
// It picks one of NSRC result sources. The load source can pass through byte/half-word
// lane extraction with sign or zero extension. The result is held in the MEM/WB
// register, with flush > stall > load priority on each edge. wb_data also drives the
// forwarding network.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid           MEM stage holds a valid instruction
//   stall, flush       hold / bubble the WB register
//   src_bus            NSRC packed sources, source i at [i*WIDTH +: WIDTH]
//   sel                source index
//   ld_size            00 word, 01 half, 10 byte, 11 reserved (treated as word, flags err)
//   ld_signed          1 = sign-extend, 0 = zero-extend
//   addr_lo            byte offset of the load address
//   rd, reg_write      destination register and its write request
//   out_valid          WB register holds a valid instruction
//   wb_we, wb_rd       register-file write enable / address (r0 never written)
//   wb_data            register-file write data and forwarding value
//   sel_err            error flag for the held instruction
//   err_sticky         set on any error, cleared only by reset
module wb_select_stage #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NSRC     = 4,
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned LOAD_SEL = 0,
    parameter int unsigned LOAD_EXT = 1,
    parameter int unsigned RA_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [NSRC*WIDTH-1:0] src_bus,
    input  logic [SEL_W-1:0]      sel,
    input  logic [1:0]            ld_size,
    input  logic                  ld_signed,
    input  logic [1:0]            addr_lo,
    input  logic [RA_W-1:0]       rd,
    input  logic                  reg_write,
    output logic                  out_valid,
    output logic                  wb_we,
    output logic [RA_W-1:0]       wb_rd,
    output logic [WIDTH-1:0]      wb_data,
    output logic                  sel_err,
    output logic                  err_sticky
);

    logic [WIDTH-1:0] selected;
    logic [WIDTH-1:0] data_d;
    logic             err;
    logic [15:0]      half;
    logic [7:0]       byte_v;

    logic             valid_q, we_q, sel_err_q, sticky_q;
    logic [RA_W-1:0]  rd_q;
    logic [WIDTH-1:0] data_q;

    // Source mux. Any index with no matching source falls through with err set.
    always_comb begin
        selected = '0;
        err      = 1'b1;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (32'(sel) == i) begin
                selected = src_bus[i*WIDTH +: WIDTH];
                err      = 1'b0;
            end
        end
    end

    // Lane extraction. Offsets use constant slices, so no variable part-selects.
    always_comb begin
        half   = addr_lo[1] ? selected[31:16] : selected[15:0];
        byte_v = selected[7:0];
        unique case (addr_lo)
            2'd0: byte_v = selected[7:0];
            2'd1: byte_v = selected[15:8];
            2'd2: byte_v = selected[23:16];
            2'd3: byte_v = selected[31:24];
            default: byte_v = selected[7:0];
        endcase
    end

    logic load_err;

    always_comb begin
        data_d   = selected;
        load_err = 1'b0;
        if (LOAD_EXT != 0 && 32'(sel) == LOAD_SEL) begin
            unique case (ld_size)
                2'b00: load_err = (addr_lo != 2'b00);
                2'b01: begin
                    data_d   = {{(WIDTH-16){ld_signed & half[15]}}, half};
                    load_err = addr_lo[0];
                end
                2'b10: data_d = {{(WIDTH-8){ld_signed & byte_v[7]}}, byte_v};
                2'b11: load_err = 1'b1;
                default: load_err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            we_q      <= 1'b0;
            rd_q      <= '0;
            data_q    <= '0;
            sel_err_q <= 1'b0;
            sticky_q  <= 1'b0;
        end else if (flush) begin
            valid_q   <= 1'b0;
            we_q      <= 1'b0;
            rd_q      <= '0;
            data_q    <= '0;
            sel_err_q <= 1'b0;
        end else if (!stall) begin
            valid_q   <= in_valid;
            we_q      <= in_valid & reg_write & (rd != '0);
            rd_q      <= rd;
            data_q    <= data_d;
            sel_err_q <= in_valid & (err | load_err);
            if (in_valid & (err | load_err)) begin
                sticky_q <= 1'b1;
            end
        end
    end

    assign out_valid  = valid_q;
    assign wb_we      = we_q;
    assign wb_rd      = rd_q;
    assign wb_data    = data_q;
    assign sel_err    = sel_err_q;
    assign err_sticky = sticky_q;

endmodule

// File: tb/tb_wb_select_stage.sv
module tb_wb_select_stage;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, stall, flush, ld_signed, reg_write;
    logic [127:0] src_bus;
    logic [1:0]   sel, ld_size, addr_lo;
    logic [4:0]   rd;

    logic        out_valid, wb_we, sel_err, err_sticky;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    // Second build with NSRC=3 so that sel=3 is out of range.
    logic        out_valid3, wb_we3, sel_err3, err_sticky3;
    logic [4:0]  wb_rd3;
    logic [31:0] wb_data3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_select_stage #(.WIDTH(32), .NSRC(4), .SEL_W(2), .LOAD_SEL(0), .LOAD_EXT(1), .RA_W(5))
    u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .src_bus(src_bus), .sel(sel), .ld_size(ld_size), .ld_signed(ld_signed),
        .addr_lo(addr_lo), .rd(rd), .reg_write(reg_write), .out_valid(out_valid),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .sel_err(sel_err),
        .err_sticky(err_sticky)
    );

    wb_select_stage #(.WIDTH(32), .NSRC(3), .SEL_W(2), .LOAD_SEL(0), .LOAD_EXT(1), .RA_W(5))
    u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .src_bus(src_bus[95:0]), .sel(sel), .ld_size(ld_size), .ld_signed(ld_signed),
        .addr_lo(addr_lo), .rd(rd), .reg_write(reg_write), .out_valid(out_valid3),
        .wb_we(wb_we3), .wb_rd(wb_rd3), .wb_data(wb_data3), .sel_err(sel_err3),
        .err_sticky(err_sticky3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " wb_we"}, 32'(wb_we), 32'd0);
        check({tag, " wb_rd"}, 32'(wb_rd), 32'd0);
        check({tag, " wb_data"}, wb_data, 32'd0);
        check({tag, " sel_err"}, 32'(sel_err), 32'd0);
        check({tag, " err_sticky"}, 32'(err_sticky), 32'd0);
        check({tag, " sticky3"}, 32'(err_sticky3), 32'd0);
    endtask

    logic [31:0] exp_sel [4];
    logic [31:0] ext_data [4];
    logic [1:0]  ext_size [4];
    logic        ext_sgn [4];
    logic [1:0]  ext_addr [4];

    initial begin
        exp_sel = '{32'hDEADBEEF, 32'h12345678, 32'h0000FFFF, 32'h00003008};
        ext_size = '{2'b10, 2'b10, 2'b01, 2'b01};
        ext_sgn  = '{1'b1, 1'b0, 1'b1, 1'b0};
        ext_addr = '{2'd0, 2'd1, 2'd2, 2'd0};
        ext_data = '{32'hFFFFFF81, 32'h0000007F, 32'hFFFF80F1, 32'h00007F81};

        // Reset with everything asserted.
        rst_n = 1'b0; src_bus = '1; in_valid = 1'b1; stall = 1'b0; flush = 1'b0;
        sel = 2'd1; ld_size = 2'b00; ld_signed = 1'b0; addr_lo = 2'd0; rd = 5'd8;
        reg_write = 1'b1;
        #2;
        check_all_zero("reset async");
        step(); step();
        check_all_zero("reset held");

        rst_n = 1'b1;
        in_valid = 1'b0;
        step();
        check("idle out_valid", 32'(out_valid), 32'd0);
        check("idle wb_we", 32'(wb_we), 32'd0);
        check("idle sel_err", 32'(sel_err), 32'd0);

        // Source select sweep.
        src_bus = {32'h00003008, 32'h0000FFFF, 32'h12345678, 32'hDEADBEEF};
        in_valid = 1'b1; rd = 5'd8; reg_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            step();
            check($sformatf("sel%0d wb_data", i), wb_data, exp_sel[i]);
            check($sformatf("sel%0d wb_we", i), 32'(wb_we), 32'd1);
            check($sformatf("sel%0d wb_rd", i), 32'(wb_rd), 32'd8);
            check($sformatf("sel%0d sel_err", i), 32'(sel_err), 32'd0);
        end
        // NSRC=3 build saw sel=3 in the last iteration.
        check("nsrc3 wb_data", wb_data3, 32'd0);
        check("nsrc3 sel_err", 32'(sel_err3), 32'd1);
        check("nsrc3 sticky", 32'(err_sticky3), 32'd1);

        // Load extension.
        src_bus[31:0] = 32'h80F17F81;
        sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            ld_size = ext_size[i]; ld_signed = ext_sgn[i]; addr_lo = ext_addr[i];
            step();
            check($sformatf("ext%0d wb_data", i), wb_data, ext_data[i]);
            check($sformatf("ext%0d sel_err", i), 32'(sel_err), 32'd0);
        end
        check("sticky still clear", 32'(err_sticky), 32'd0);
        check("nsrc3 sticky holds", 32'(err_sticky3), 32'd1);
        check("nsrc3 clean sel_err", 32'(sel_err3), 32'd0);

        // Load fields ignored for non-load sources.
        sel = 2'd1; ld_size = 2'b11; addr_lo = 2'd1;
        step();
        check("nonload data", wb_data, 32'h12345678);
        check("nonload sel_err", 32'(sel_err), 32'd0);

        // Load errors.
        sel = 2'd0; ld_size = 2'b01; ld_signed = 1'b0; addr_lo = 2'd1;
        step();
        check("half misalign sel_err", 32'(sel_err), 32'd1);
        check("half misalign sticky", 32'(err_sticky), 32'd1);
        ld_size = 2'b00; addr_lo = 2'd2;
        step();
        check("word misalign data", wb_data, 32'h80F17F81);
        check("word misalign sel_err", 32'(sel_err), 32'd1);
        ld_size = 2'b11; addr_lo = 2'd0;
        step();
        check("reserved size data", wb_data, 32'h80F17F81);
        check("reserved size sel_err", 32'(sel_err), 32'd1);
        in_valid = 1'b0;
        step();
        check("invalid no sel_err", 32'(sel_err), 32'd0);
        check("invalid data loads", wb_data, 32'h80F17F81);
        check("invalid no we", 32'(wb_we), 32'd0);
        check("sticky persists", 32'(err_sticky), 32'd1);

        // Stall holds.
        in_valid = 1'b1; ld_size = 2'b00; sel = 2'd1; rd = 5'd8;
        step();
        check("pre-stall data", wb_data, 32'h12345678);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sel = 2'(i + 2); rd = 5'(i + 9); in_valid = i[0];
            step();
            check($sformatf("stall%0d data", i), wb_data, 32'h12345678);
            check($sformatf("stall%0d rd", i), 32'(wb_rd), 32'd8);
            check($sformatf("stall%0d valid", i), 32'(out_valid), 32'd1);
            check($sformatf("stall%0d we", i), 32'(wb_we), 32'd1);
        end

        // Flush wins over stall.
        flush = 1'b1;
        step();
        check("flush out_valid", 32'(out_valid), 32'd0);
        check("flush wb_we", 32'(wb_we), 32'd0);
        check("flush wb_data", wb_data, 32'd0);
        check("flush wb_rd", 32'(wb_rd), 32'd0);
        check("flush keeps sticky", 32'(err_sticky), 32'd1);

        // Register 0 never written; reg_write=0 also blocks.
        flush = 1'b0; stall = 1'b0; in_valid = 1'b1; reg_write = 1'b1; rd = 5'd0; sel = 2'd2;
        step();
        check("r0 wb_we", 32'(wb_we), 32'd0);
        check("r0 out_valid", 32'(out_valid), 32'd1);
        rd = 5'd5; reg_write = 1'b0;
        step();
        check("no reg_write wb_we", 32'(wb_we), 32'd0);

        // Reset mid-stall clears everything, sticky included.
        reg_write = 1'b1; sel = 2'd1;
        step();
        check("pre-reset we", 32'(wb_we), 32'd1);
        stall = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        check_all_zero("reset mid-stall");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
